uart_tx_arbiter: RTL
====================

Name: uart_tx_arbiter

Overview:
- Round-robin arbiter that shares the UART transmit FIFO push port between NUM_REQ byte-stream requesters (e.g. CPU console, debug monitor, DMA).
- A grant is locked for one burst: until the requester flags the last byte, or until MAX_BURST bytes have been accepted. This keeps messages contiguous on tx_o and stops any one requester starving the others.
- It sits between the requester valid/ready streams and the TX FIFO write side of the UART, with a single registered output stage.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- DATA_W, 8, byte width pushed into the TX FIFO.
- MAX_BURST, 16, maximum bytes accepted per grant before a forced re-arbitration (1..256).

Ports:
- clk_i  in  1  system clock.
- rst_ni  in  1  reset; asynchronous, active-low.
- enable_i  in  1  1 = new grants allowed; 0 = finish the current burst, then hold IDLE.
- req_valid_i  in  NUM_REQ  per-requester byte valid.
- req_data_i  in  NUM_REQ*DATA_W  packed bytes; requester k uses bits [k*DATA_W +: DATA_W].
- req_last_i  in  NUM_REQ  the byte presented is the last of the message.
- req_ready_o  out  NUM_REQ  per-requester accept; at most one bit set.
- fifo_full_i  in  1  TX FIFO full.
- fifo_push_o  out  1  TX FIFO push strobe.
- fifo_wdata_o  out  DATA_W  byte to push.
- grant_o  out  NUM_REQ  one-hot owner; 0 in IDLE.
- busy_o  out  1  1 when in LOCK or the output stage is valid.

Behaviour:
- Reset (asynchronous, rst_ni=0) clears everything immediately:
  - state=IDLE, rr_ptr=0, burst_cnt=0, out_valid=0.
  - fifo_push_o=0, fifo_wdata_o=0, req_ready_o=0, grant_o=0, busy_o=0.
  - A reset asserted mid-burst discards the held byte and no push follows.
- FSM states: IDLE, LOCK.
- IDLE:
  - If enable_i=1 and any req_valid_i=1, select the first valid index scanning upward from rr_ptr, wrapping modulo NUM_REQ.
  - Register the owner and assert grant_o, then move to LOCK on the next cycle. Arbitration costs 1 cycle.
  - req_ready_o=0 in IDLE.
- LOCK:
  - req_ready_o[owner] = req_valid_i[owner] is not required; ready = !out_valid || !fifo_full_i.
  - Accept = req_valid_i[owner] && req_ready_o[owner]. On accept:
    - The output register loads the byte and out_valid=1.
    - burst_cnt increments.
  - Leave LOCK on the accepting cycle when req_last_i[owner]=1 or burst_cnt==MAX_BURST-1. Then:
    - next state IDLE, rr_ptr=owner+1 (wrapping), burst_cnt=0, grant_o=0 next cycle.
  - An owner that deasserts valid mid-burst keeps the lock; there is no timeout.
  - enable_i=0 has no effect inside LOCK.
- Output stage:
  - fifo_push_o = out_valid && !fifo_full_i; fifo_wdata_o = held byte.
  - out_valid clears on push unless a new byte is accepted in the same cycle.
  - Latency from accept to push is 1 cycle when the FIFO is not full.
  - Sustained throughput is 1 byte/cycle.
  - With fifo_full_i=1 the byte is held and ready drops. No byte is ever lost or duplicated.
- A byte accepted on the exiting cycle is still pushed after the return to IDLE; busy_o stays 1 until it is pushed.
- Fairness: a continuously requesting requester waits at most (NUM_REQ-1) bursts plus arbitration cycles.
- busy_o = (state==LOCK) || out_valid.
- Widths:
  - burst_cnt is $clog2(MAX_BURST+1) bits.
  - rr_ptr and owner are $clog2(NUM_REQ) bits, with explicit wrap (no reliance on power-of-two NUM_REQ).

Decomposition:
- uart_pkg holds: the arb_state_e typedef {IDLE, LOCK}, the DATA_W default, and the UART register address constants shared with the UART core.
- One sub-module, rr_pick: combinational round-robin priority picker with inputs valid vector and start pointer, outputs one-hot vector, index and found flag. It is reusable by an RX-side demultiplexer later.

Test Plan:
- Single requester, req1 sends 0x41, 0x42, 0x43 (last on 0x43), FIFO empty:
  - grant_o=0b0010 one cycle after valid.
  - Pushes 0x41, 0x42, 0x43 on consecutive cycles.
  - grant_o=0 after the last byte.
  - busy_o falls one cycle after the final push.
- All four requesters valid with 2-byte messages, rr_ptr=0:
  - Grant order 0, 1, 2, 3, 0.
  - Each message is contiguous in FIFO order and no interleaving occurs.
- req2 streams 20 bytes with no last, MAX_BURST=16, req3 also valid:
  - Exactly 16 bytes are pushed, then req3 is granted.
  - req2 resumes at byte 17 afterwards.
- fifo_full_i high for 5 cycles mid-burst:
  - fifo_push_o=0 and the held byte is stable during stall.
  - After full drops, the held byte is pushed once and sequence order is preserved.
- Owner drops valid for 3 cycles mid-message while req0 is valid:
  - Lock is held and req0 is not granted until the owner's last byte.
- rst_ni asserted while in LOCK with out_valid=1:
  - All outputs are 0 immediately.
  - After release, the first grant goes to the lowest valid index (rr_ptr=0).

Source files
------------

// File: rtl/uart_pkg.sv
// Shared UART definitions: arbiter FSM states, default byte width and the
// register map used by the UART core.
package uart_pkg;

  typedef enum logic [0:0] {
    IDLE = 1'b0,
    LOCK = 1'b1
  } arb_state_e;

  localparam int unsigned DataWDefault = 8;

  localparam logic [7:0] UartTxDataAddr = 8'h00;
  localparam logic [7:0] UartRxDataAddr = 8'h04;
  localparam logic [7:0] UartStatusAddr = 8'h08;
  localparam logic [7:0] UartCtrlAddr   = 8'h0C;
  localparam logic [7:0] UartBaudAddr   = 8'h10;

endpackage

// File: rtl/uart_tx_arbiter_if.sv
// Requester streams and TX FIFO write side of the UART transmit arbiter.
// The arbiter takes the slave view; whoever drives the requesters takes master.
interface uart_tx_arbiter_if #(
    parameter int unsigned NUM_REQ = 4,
    parameter int unsigned DATA_W  = 8
);

    logic                      enable_i;
    logic [NUM_REQ-1:0]        req_valid_i;
    logic [NUM_REQ*DATA_W-1:0] req_data_i;
    logic [NUM_REQ-1:0]        req_last_i;
    logic [NUM_REQ-1:0]        req_ready_o;
    logic                      fifo_full_i;
    logic                      fifo_push_o;
    logic [DATA_W-1:0]         fifo_wdata_o;
    logic [NUM_REQ-1:0]        grant_o;
    logic                      busy_o;

    modport master (
        output enable_i, req_valid_i, req_data_i, req_last_i, fifo_full_i,
        input  req_ready_o, fifo_push_o, fifo_wdata_o, grant_o, busy_o
    );

    modport slave (
        input  enable_i, req_valid_i, req_data_i, req_last_i, fifo_full_i,
        output req_ready_o, fifo_push_o, fifo_wdata_o, grant_o, busy_o
    );

endinterface

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set bit of valid at or above start,
// wrapping at N. Works for any N, not only powers of two.
module rr_pick #(
    parameter int unsigned N    = 4,
    parameter int unsigned IdxW = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]    valid,
    input  logic [IdxW-1:0] start,
    output logic [N-1:0]    onehot,
    output logic [IdxW-1:0] idx,
    output logic            found
);

    always_comb begin
        int unsigned pos;
        onehot = '0;
        idx    = '0;
        found  = 1'b0;
        pos    = 0;
        for (int unsigned i = 0; i < N; i++) begin
            pos = 32'(start) + i;
            if (pos >= N) begin
                pos = pos - N;
            end
            if (!found && valid[pos]) begin
                found       = 1'b1;
                idx         = IdxW'(pos);
                onehot[pos] = 1'b1;
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin, burst-locked arbiter sharing the UART TX FIFO push port between
// NUM_REQ byte streams, with one registered output stage in front of the FIFO.
module uart_tx_arbiter
    import uart_pkg::*;
#(
    parameter int unsigned NUM_REQ   = 4,
    parameter int unsigned DATA_W    = DataWDefault,
    parameter int unsigned MAX_BURST = 16
) (
    input  logic              clk_i,
    input  logic              rst_ni,
    uart_tx_arbiter_if.slave  bus
);

    localparam int unsigned IdxW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
    localparam int unsigned CntW = $clog2(MAX_BURST + 1);

    arb_state_e         state_q, state_d;
    logic [IdxW-1:0]    owner_q, owner_d;
    logic [IdxW-1:0]    rr_ptr_q, rr_ptr_d;
    logic [NUM_REQ-1:0] grant_q, grant_d;
    logic [CntW-1:0]    burst_cnt_q, burst_cnt_d;
    logic               out_valid_q, out_valid_d;
    logic [DATA_W-1:0]  out_data_q, out_data_d;

    logic [NUM_REQ-1:0] pick_onehot;
    logic [IdxW-1:0]    pick_idx;
    logic               pick_found;
    logic               ready;
    logic               accept;
    logic               push;
    logic               last_beat;

    rr_pick #(
        .N    (NUM_REQ),
        .IdxW (IdxW)
    ) u_rr_pick (
        .valid  (bus.req_valid_i),
        .start  (rr_ptr_q),
        .onehot (pick_onehot),
        .idx    (pick_idx),
        .found  (pick_found)
    );

    always_comb begin
        state_d     = state_q;
        owner_d     = owner_q;
        rr_ptr_d    = rr_ptr_q;
        grant_d     = grant_q;
        burst_cnt_d = burst_cnt_q;
        out_data_d  = out_data_q;
        ready       = 1'b0;
        accept      = 1'b0;
        last_beat   = 1'b0;
        push        = out_valid_q && !bus.fifo_full_i;
        // A push drains the stage; an accept in the same cycle refills it.
        out_valid_d = out_valid_q && !push;

        unique case (state_q)
            IDLE: begin
                if (bus.enable_i && pick_found) begin
                    owner_d = pick_idx;
                    grant_d = pick_onehot;
                    state_d = LOCK;
                end
            end
            LOCK: begin
                ready  = !out_valid_q || !bus.fifo_full_i;
                accept = ready && bus.req_valid_i[owner_q];
                if (accept) begin
                    out_data_d  = bus.req_data_i[owner_q*DATA_W +: DATA_W];
                    out_valid_d = 1'b1;
                    last_beat   = bus.req_last_i[owner_q] ||
                                  (burst_cnt_q == CntW'(MAX_BURST - 1));
                    if (last_beat) begin
                        state_d     = IDLE;
                        grant_d     = '0;
                        burst_cnt_d = '0;
                        rr_ptr_d    = (owner_q == IdxW'(NUM_REQ - 1)) ? '0
                                                                      : owner_q + IdxW'(1);
                    end else begin
                        burst_cnt_d = burst_cnt_q + CntW'(1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= IDLE;
            owner_q     <= '0;
            rr_ptr_q    <= '0;
            grant_q     <= '0;
            burst_cnt_q <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
        end else begin
            state_q     <= state_d;
            owner_q     <= owner_d;
            rr_ptr_q    <= rr_ptr_d;
            grant_q     <= grant_d;
            burst_cnt_q <= burst_cnt_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
        end
    end

    always_comb begin
        bus.req_ready_o          = '0;
        bus.req_ready_o[owner_q] = ready;
    end

    assign bus.fifo_push_o  = push;
    assign bus.fifo_wdata_o = out_data_q;
    assign bus.grant_o      = grant_q;
    assign bus.busy_o       = (state_q == LOCK) || out_valid_q;

endmodule
